// File: rtl/booth_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : booth_prod_accum
// Brief    : Saturating 16-bit multiply-accumulate back end for the 4x4 Booth
//            multiplier. Sums signed products per block and, on the block's
//            last product, streams the sum out as two bytes (low, then high)
//            over a valid/ready byte port.
// Revision : 1.0 - initial release
// ============================================================================
module booth_prod_accum #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    input  logic              clear,
    output logic [OUT_W-1:0]  out_byte,
    output logic              out_hi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sat_flag,
    output logic [7:0]        term_cnt
);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_OUT_LO = 2'd1,
        ST_OUT_HI = 2'd2
    } state_t;

    // Saturation limits expressed at the one-bit-wider sum width
    localparam logic signed [ACC_W:0] c_SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]            c_CNT_MAX = 8'hFF;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     result_q, result_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    // Set when a drain finishes: the next block restarts its count/flag
    logic                 fresh_q, fresh_d;
    logic [OUT_W-1:0]     out_byte_q, out_byte_d;
    logic                 out_hi_q, out_hi_d;
    logic                 out_valid_q, out_valid_d;

    logic                 w_accept;
    logic                 w_restart;
    logic [ACC_W-1:0]     w_acc_base;
    logic [7:0]           w_cnt_base;
    logic                 w_sat_base;
    logic signed [ACC_W:0] w_sum;
    logic [ACC_W-1:0]     w_sat_sum;
    logic                 w_sat_hit;

    assign prod_ready = (state_q == ST_ACCUM) && !rst;
    assign w_accept   = prod_valid && prod_ready;

    // Clear takes effect before the same-cycle product; a finished drain acts
    // as a clear of the block statistics (accumulator is already zero then)
    assign w_restart  = clear || fresh_q;
    assign w_acc_base = clear     ? '0   : acc_q;
    assign w_cnt_base = w_restart ? 8'd0 : cnt_q;
    assign w_sat_base = w_restart ? 1'b0 : sat_q;

    // Sign-extended add at ACC_W+1 bits, then clamp to the ACC_W range
    always_comb begin
        w_sum     = $signed({w_acc_base[ACC_W-1], w_acc_base})
                  + $signed({{(ACC_W+1-PROD_W){prod_data[PROD_W-1]}}, prod_data});
        w_sat_hit = 1'b0;
        w_sat_sum = w_sum[ACC_W-1:0];
        if (w_sum > c_SUM_MAX) begin
            w_sat_sum = c_SUM_MAX[ACC_W-1:0];
            w_sat_hit = 1'b1;
        end else if (w_sum < c_SUM_MIN) begin
            w_sat_sum = c_SUM_MIN[ACC_W-1:0];
            w_sat_hit = 1'b1;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        fresh_d     = fresh_q;
        out_byte_d  = out_byte_q;
        out_hi_d    = out_hi_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_ACCUM: begin
                if (clear) begin
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                    sat_d   = 1'b0;
                    fresh_d = 1'b0;
                end
                if (w_accept) begin
                    fresh_d = 1'b0;
                    cnt_d   = (w_cnt_base == c_CNT_MAX) ? c_CNT_MAX : w_cnt_base + 8'd1;
                    sat_d   = w_sat_base | w_sat_hit;
                    if (prod_last) begin
                        acc_d       = '0;
                        result_d    = w_sat_sum;
                        state_d     = ST_OUT_LO;
                        out_valid_d = 1'b1;
                        out_hi_d    = 1'b0;
                        out_byte_d  = w_sat_sum[OUT_W-1:0];
                    end else begin
                        acc_d = w_sat_sum;
                    end
                end
            end
            ST_OUT_LO: begin
                if (out_ready) begin
                    state_d    = ST_OUT_HI;
                    out_hi_d   = 1'b1;
                    out_byte_d = result_q[ACC_W-1:OUT_W];
                end
            end
            ST_OUT_HI: begin
                if (out_ready) begin
                    state_d     = ST_ACCUM;
                    out_valid_d = 1'b0;
                    fresh_d     = 1'b1;
                end
            end
            default: begin
                state_d     = ST_ACCUM;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            result_q    <= '0;
            cnt_q       <= 8'd0;
            sat_q       <= 1'b0;
            fresh_q     <= 1'b0;
            out_byte_q  <= '0;
            out_hi_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            fresh_q     <= fresh_d;
            out_byte_q  <= out_byte_d;
            out_hi_q    <= out_hi_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_byte  = out_byte_q;
    assign out_hi    = out_hi_q;
    assign out_valid = out_valid_q;
    assign sat_flag  = sat_q;
    assign term_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_prod_accum.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_booth_prod_accum
// Brief    : Directed-vector bench for booth_prod_accum. Expected bytes are
//            queued when a block is issued; a monitor pops and compares on
//            every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_prod_accum;

    logic       clk;
    logic       rst;
    logic [7:0] prod_data;
    logic       prod_valid;
    logic       prod_last;
    logic       prod_ready;
    logic       clear;
    logic [7:0] out_byte;
    logic       out_hi;
    logic       out_valid;
    logic       out_ready;
    logic       sat_flag;
    logic [7:0] term_cnt;

    typedef struct packed {
        logic [7:0] b;
        logic       hi;
        logic [7:0] cnt;
        logic       sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    booth_prod_accum #(.PROD_W(8), .ACC_W(16), .OUT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .clear      (clear),
        .out_byte   (out_byte),
        .out_hi     (out_hi),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat_flag   (sat_flag),
        .term_cnt   (term_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every byte handshaken at the coming edge is checked against the queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got byte=%h hi=%b, nothing expected", out_byte, out_hi);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_byte !== e.b || out_hi !== e.hi || term_cnt !== e.cnt || sat_flag !== e.sat) begin
                    errors++;
                    $display("FAIL out_byte: got byte=%h hi=%b cnt=%0d sat=%b, expected byte=%h hi=%b cnt=%0d sat=%b",
                             out_byte, out_hi, term_cnt, sat_flag, e.b, e.hi, e.cnt, e.sat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push_block(input logic [7:0] lo, input logic [7:0] hi,
                              input logic [7:0] cnt, input logic sat);
        sb.push_back('{b: lo, hi: 1'b0, cnt: cnt, sat: sat});
        sb.push_back('{b: hi, hi: 1'b1, cnt: cnt, sat: sat});
    endtask

    // Present one product and hold it until the stage accepts it
    task automatic send(input logic [7:0] d, input logic l, input logic c);
        logic r;
        int   n;
        n = 0;
        prod_data  = d;
        prod_valid = 1'b1;
        prod_last  = l;
        clear      = c;
        forever begin
            @(negedge clk);
            r = prod_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: product %h never accepted", d);
                break;
            end
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", sb.size());
        end
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid_rise", {15'd0, out_valid}, 16'd1);
    endtask

    initial begin
        rst        = 1'b1;
        prod_data  = 8'h00;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_prod_ready", {15'd0, prod_ready}, 16'd0);
        chk("rst_out_valid",  {15'd0, out_valid},  16'd0);
        chk("rst_out_byte",   {8'd0, out_byte},    16'd0);
        chk("rst_out_hi",     {15'd0, out_hi},     16'd0);
        chk("rst_term_cnt",   {8'd0, term_cnt},    16'd0);
        chk("rst_sat_flag",   {15'd0, sat_flag},   16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_prod_ready", {15'd0, prod_ready}, 16'd1);

        // Basic block: 12 - 10 + 5 = 7
        push_block(8'h07, 8'h00, 8'd3, 1'b0);
        send(8'h0C, 1'b0, 1'b0);
        send(8'hF6, 1'b0, 1'b0);
        send(8'h05, 1'b1, 1'b0);
        wait_drain();

        // Negative result: -15 + -15 = -30 = 0xFFE2, ready low two cycles
        push_block(8'hE2, 8'hFF, 8'd2, 1'b0);
        send(8'hF1, 1'b0, 1'b0);
        send(8'hF1, 1'b1, 1'b0);
        @(negedge clk);
        chk("turn_ready_c1", {15'd0, prod_ready}, 16'd0);
        @(negedge clk);
        chk("turn_ready_c2", {15'd0, prod_ready}, 16'd0);
        @(negedge clk);
        chk("turn_ready_c3", {15'd0, prod_ready}, 16'd1);
        wait_drain();

        // Positive saturation: 300 * 127 clamps to 0x7FFF, count holds at 255
        push_block(8'hFF, 8'h7F, 8'd255, 1'b1);
        for (int i = 0; i < 300; i++) send(8'h7F, (i == 299), 1'b0);
        wait_drain();

        // Negative saturation: 300 * -128 clamps to 0x8000
        push_block(8'h00, 8'h80, 8'd255, 1'b1);
        for (int i = 0; i < 300; i++) send(8'h80, (i == 299), 1'b0);
        wait_drain();

        // Backpressure on the low byte for five cycles
        out_ready = 1'b0;
        push_block(8'h11, 8'h00, 8'd1, 1'b0);
        send(8'h11, 1'b1, 1'b0);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_byte",  {8'd0, out_byte},    16'h0011);
            chk("bp_hi",    {15'd0, out_hi},     16'd0);
            chk("bp_valid", {15'd0, out_valid},  16'd1);
            chk("bp_ready", {15'd0, prod_ready}, 16'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hi_next", {15'd0, out_hi}, 16'd1);
        wait_drain();

        // Clear collision: 100 is discarded, 3 + 2 = 5
        push_block(8'h05, 8'h00, 8'd2, 1'b0);
        send(8'h64, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b1);
        send(8'h02, 1'b1, 1'b0);
        wait_drain();

        // Reset during the high byte
        out_ready = 1'b0;
        sb.push_back('{b: 8'h7E, hi: 1'b0, cnt: 8'd1, sat: 1'b0});
        send(8'h7E, 1'b1, 1'b0);
        wait_out_valid();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("pre_rst_hi", {15'd0, out_hi}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {15'd0, out_valid},  16'd0);
        chk("mid_rst_byte",  {8'd0, out_byte},    16'd0);
        chk("mid_rst_ready", {15'd0, prod_ready}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_cnt", {8'd0, term_cnt}, 16'd0);
        push_block(8'h01, 8'h00, 8'd1, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        wait_drain();

        repeat (3) @(posedge clk);
        chk("queue_empty", sb.size(), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
